palette_ram_lut: RTL and testbench

Parametrised, CPU-writable colour palette for the video path. Converts a per-pixel palette index into packed R/G/B DAC drive once per pixel (on the rising edge of `h_half`), with composite blanking. Replaces fixed-PROM palettes with a single-port RAM that clears itself after reset and is loaded by the Z80-side bus through a req/ack handshake. Sits between the tile/sprite mixer and the video DAC.

---
 rtl/palette_ram_lut.sv | 197 +++++++++++++++++++
 tb/tb_palette_ram_lut.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_ram_lut.sv
// rtl/palette_ram_lut.sv - CPU-writable colour palette RAM with self-clearing init and pixel lookup
//
// Purpose:
//   Converts a per-pixel palette index into packed R/G/B DAC drive. One lookup
//   starts on each rising edge of h_half. Composite blanking forces the colour to
//   zero. The palette lives in a single-port RAM. The RAM is cleared after every
//   reset and is loaded by the CPU through a req/ack handshake.
//
// Configuration macro:
//   PALETTE_READBACK_EN - when defined, CPU reads return RAM[cpu_addr] on cpu_rdata.
//                         When undefined, reads only complete the handshake and
//                         cpu_rdata is tied to 0.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   h_half              pixel phase; a rising edge starts one lookup
//   cmpblk              composite blank, carried with the lookup
//   idx                 palette index for the pixel
//   cpu_req/cpu_we      CPU access request (held until ack) / 1 = write
//   cpu_addr/cpu_wdata  CPU entry address and write data
//   cpu_ack             one-cycle access-complete pulse
//   cpu_rdata           read data, valid while cpu_ack is high
//   init_busy           high while the post-reset clear runs
//   r_sig/g_sig/b_sig   colour outputs; entry is packed {B,G,R} with R in the LSBs

module palette_ram_lut #(
    parameter int IDX_W = 8,
    parameter int R_W   = 3,
    parameter int G_W   = 3,
    parameter int B_W   = 2,
    localparam int D_W  = R_W + G_W + B_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             h_half,
    input  logic             cmpblk,
    input  logic [IDX_W-1:0] idx,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [IDX_W-1:0] cpu_addr,
    input  logic [D_W-1:0]   cpu_wdata,
    output logic             cpu_ack,
    output logic [D_W-1:0]   cpu_rdata,
    output logic             init_busy,
    output logic [R_W-1:0]   r_sig,
    output logic [G_W-1:0]   g_sig,
    output logic [B_W-1:0]   b_sig
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W:0] LAST_ENTRY = (IDX_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDX_W:0]   init_cnt_q;
    logic             init_busy_q;
    logic             ack_q;
    logic             h_half_q;
    logic             lookup_q;
    logic             blk_q;
    logic [R_W-1:0]   r_q;
    logic [G_W-1:0]   g_q;
    logic [B_W-1:0]   b_q;

    logic [D_W-1:0]   mem [DEPTH];
    logic [D_W-1:0]   rd_q;

    logic             pix_edge;
    logic             pix_rd;
    logic             cpu_go;
    logic             cpu_ram;
    logic             ram_en;
    logic             ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [D_W-1:0]   ram_wdata;

    // Pixel edge is combinational on the live h_half so the RAM read happens
    // at the end of the same cycle the rising edge is seen.
    assign pix_edge = h_half & ~h_half_q;
    assign pix_rd   = (state_q == S_IDLE) & pix_edge;
    // The pixel path owns the single RAM port whenever it needs it. A colliding
    // CPU request waits one cycle.
    assign cpu_go   = (state_q == S_IDLE) & ~pix_edge & cpu_req;

`ifdef PALETTE_READBACK_EN
    assign cpu_ram   = cpu_go;
    assign cpu_rdata = ack_q ? rd_q : '0;
`else
    // Reads complete the handshake without touching the RAM.
    assign cpu_ram   = cpu_go & cpu_we;
    assign cpu_rdata = '0;
`endif

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = idx;
        ram_wdata = '0;
        if (rst_n) begin
            if (state_q == S_INIT) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = init_cnt_q[IDX_W-1:0];
            end else if (pix_rd) begin
                ram_en   = 1'b1;
                ram_addr = idx;
            end else if (cpu_ram) begin
                ram_en    = 1'b1;
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
        end
    end

    // Single-port RAM with a registered read. The array has no reset. The
    // INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
            end else begin
                rd_q <= mem[ram_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            init_busy_q <= 1'b1;
            ack_q       <= 1'b0;
            h_half_q    <= 1'b0;
            lookup_q    <= 1'b0;
            blk_q       <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else begin
            h_half_q <= h_half;
            lookup_q <= pix_rd;
            blk_q    <= cmpblk;
            ack_q    <= 1'b0;

            // Output stage: rd_q holds the entry one cycle after the pixel read.
            if (lookup_q) begin
                if (blk_q) begin
                    r_q <= '0;
                    g_q <= '0;
                    b_q <= '0;
                end else begin
                    r_q <= rd_q[R_W-1:0];
                    g_q <= rd_q[R_W +: G_W];
                    b_q <= rd_q[R_W+G_W +: B_W];
                end
            end

            case (state_q)
                S_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LAST_ENTRY) begin
                        state_q     <= S_IDLE;
                        init_busy_q <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (cpu_go) begin
                        state_q <= S_DONE;
                        ack_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Wait for the request to drop so one request yields one access.
                    if (!cpu_req) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign cpu_ack   = ack_q;
    assign init_busy = init_busy_q;
    assign r_sig     = r_q;
    assign g_sig     = g_q;
    assign b_sig     = b_q;

endmodule

// File: tb/tb_palette_ram_lut.sv
// tb/tb_palette_ram_lut.sv - scoreboard bench for palette_ram_lut

module tb_palette_ram_lut;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       h_half;
    logic       cmpblk;
    logic [7:0] idx;
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       init_busy;
    logic [2:0] r_sig;
    logic [2:0] g_sig;
    logic [1:0] b_sig;

    palette_ram_lut dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_half    (h_half),
        .cmpblk    (cmpblk),
        .idx       (idx),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .init_busy (init_busy),
        .r_sig     (r_sig),
        .g_sig     (g_sig),
        .b_sig     (b_sig)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] val;
    } pix_exp_t;

    typedef struct {
        int         due;
        bit         chk;
        logic [7:0] rdata;
    } ack_exp_t;

    pix_exp_t pix_q[$];
    ack_exp_t ack_q[$];

    int total = 0;
    int bad   = 0;

`ifdef PALETTE_READBACK_EN
    localparam logic [7:0] RB_EXP = 8'h3C;
`else
    localparam logic [7:0] RB_EXP = 8'h00;
`endif

    // Monitor: compares DUT outputs against the expectation queues.
    always @(negedge clk) begin
        if (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            pix_exp_t e;
            e = pix_q.pop_front();
            total++;
            if (e.due != cyc) begin
                bad++;
                $display("FAIL pixel_slot cyc=%0d expected slot %0d was skipped", cyc, e.due);
            end else if ({b_sig, g_sig, r_sig} !== e.val) begin
                bad++;
                $display("FAIL pixel cyc=%0d got=%02h want=%02h", cyc, {b_sig, g_sig, r_sig}, e.val);
            end
        end
        if (cpu_ack === 1'b1) begin
            total++;
            if (ack_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack cyc=%0d got=1 want=0", cyc);
            end else begin
                ack_exp_t a;
                a = ack_q.pop_front();
                if (a.due != cyc) begin
                    bad++;
                    $display("FAIL ack_cycle got=%0d want=%0d", cyc, a.due);
                end else if (a.chk && cpu_rdata !== a.rdata) begin
                    bad++;
                    $display("FAIL cpu_rdata got=%02h want=%02h", cpu_rdata, a.rdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        h_half  = 1'b0;
        step();
        step();
        @(negedge clk);
        total++;
        if (cpu_ack !== 1'b0 || init_busy !== 1'b1 || cpu_rdata !== 8'h00 ||
            {b_sig, g_sig, r_sig} !== 8'h00) begin
            bad++;
            $display("FAIL reset_state got ack=%b busy=%b rdata=%02h rgb=%02h want 0/1/00/00",
                     cpu_ack, init_busy, cpu_rdata, {b_sig, g_sig, r_sig});
        end
        step();
        rst_n = 1'b1;
    endtask

    // Counts init_busy cycles from reset release. Expected: 256.
    task automatic wait_init();
        int n = 0;
        @(negedge clk);
        while (init_busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL init_len got=%0d want=256", n);
        end
        step();
    endtask

    task automatic pixel(input logic [7:0] i, input logic blk, input logic [7:0] want);
        pix_exp_t e;
        h_half = 1'b1;
        idx    = i;
        cmpblk = blk;
        e.due = cyc + 2; e.val = want; pix_q.push_back(e);
        e.due = cyc + 3; e.val = want; pix_q.push_back(e);
        step();
        h_half = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic wait_ack();
        int n = 0;
        @(negedge clk);
        while (cpu_ack !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (cpu_ack !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ack_timeout got=0 want=1");
        end
    endtask

    task automatic cpu_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                              input bit chk, input logic [7:0] want);
        ack_exp_t x;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        x.due = cyc + 1; x.chk = chk; x.rdata = want;
        ack_q.push_back(x);
        wait_ack();
        cpu_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        ack_exp_t x;
        pix_exp_t e;
        rst_n = 1'b0; h_half = 1'b0; cmpblk = 1'b0; idx = 8'h00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;

        do_reset();
        wait_init();
        pixel(8'h00, 1'b0, 8'h00);
        pixel(8'hFF, 1'b0, 8'h00);

        // 0xA5 -> r=5 g=4 b=2
        cpu_access(1'b1, 8'h12, 8'hA5, 1'b0, 8'h00);
        pixel(8'h12, 1'b0, 8'hA5);

        // Collision: pixel first with the old value, ack one cycle late.
        h_half = 1'b1; idx = 8'h12; cmpblk = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h12; cpu_wdata = 8'h3B;
        e.due = cyc + 2; e.val = 8'hA5; pix_q.push_back(e);
        e.due = cyc + 3; e.val = 8'hA5; pix_q.push_back(e);
        x.due = cyc + 2; x.chk = 1'b0; x.rdata = 8'h00; ack_q.push_back(x);
        step();
        h_half = 1'b0;
        wait_ack();
        cpu_req = 1'b0;
        step();
        step();
        step();
        pixel(8'h12, 1'b0, 8'h3B);

        // Blanking
        cpu_access(1'b1, 8'h33, 8'h5A, 1'b0, 8'h00);
        pixel(8'h33, 1'b1, 8'h00);
        pixel(8'h33, 1'b0, 8'h5A);

        // Readback
        cpu_access(1'b1, 8'hFF, 8'h3C, 1'b0, 8'h00);
        cpu_access(1'b0, 8'hFF, 8'h00, 1'b1, RB_EXP);

        // Reset while in DONE, request dropped.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h77;
        x.due = cyc + 1; x.chk = 1'b0; x.rdata = 8'h00; ack_q.push_back(x);
        wait_ack();
        step();
        do_reset();

        // Reset mid-INIT. A pixel during INIT must stay black.
        repeat (50) step();
        pixel(8'h12, 1'b0, 8'h00);
        do_reset();
        wait_init();

        // The palette must be cleared again.
        pixel(8'h12, 1'b0, 8'h00);
        pixel(8'h40, 1'b0, 8'h00);
        pixel(8'h33, 1'b0, 8'h00);

        repeat (10) step();
        total++;
        if (pix_q.size() != 0 || ack_q.size() != 0) begin
            bad++;
            $display("FAIL leftover got pix=%0d ack=%0d want 0/0", pix_q.size(), ack_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
